// File: rtl/ram_hex_dumper_pkg.sv
// ram_hex_dumper_pkg: shared state encodings, ASCII constants and nibble-to-hex mapping
package ram_hex_dumper_pkg;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, LATCH, SEND, WAIT_TX, NEXT, FINISH} state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
endpackage

// File: rtl/ram_hex_dumper_uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer, idle high, one-cycle tx_done after the stop bit
module uart_tx_byte
  import ram_hex_dumper_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  tx_state_t st_q, st_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shr_q, shr_d;
  logic tx_q, tx_d, done_q, done_d, last;
  assign last = cnt_q == LAST_CNT;
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    shr_d = shr_q;
    tx_d = tx_q;
    done_d = 1'b0;
    if (st_q == TX_IDLE) begin
      if (tx_start) begin
        st_d = TX_START;
        shr_d = tx_data;
        tx_d = 1'b0;
        cnt_d = 16'd0;
      end
    end else if (!last) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = 16'd0;
      if (st_q == TX_START) begin
        st_d = TX_DATA;
        bit_d = 3'd0;
        tx_d = shr_q[0];
      end else if (st_q == TX_DATA) begin
        st_d = (bit_q == 3'd7) ? TX_STOP : TX_DATA;
        tx_d = (bit_q == 3'd7) ? 1'b1 : shr_q[1];
        shr_d = shr_q >> 1;
        bit_d = bit_q + 3'd1;
      end else begin
        st_d = TX_IDLE;
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= TX_IDLE;
      cnt_q <= 16'd0;
      bit_q <= 3'd0;
      shr_q <= 8'd0;
      tx_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shr_q <= shr_d;
      tx_q <= tx_d;
      done_q <= done_d;
    end
  end
  assign tx = tx_q;
  assign tx_busy = st_q != TX_IDLE;
  assign tx_done = done_q;
endmodule

// File: rtl/ram_hex_dumper.sv
// ram_hex_dumper: reads NUM_WORDS RAM words and sends each as "HHHH\r\n" over UART
module ram_hex_dumper
  import ram_hex_dumper_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_WORDS = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic              uart_tx,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] nib;
  logic [7:0] tx_data;
  logic tx_start, tx_busy, tx_done;
  assign nib = idx_q == 3'd0 ? word_q[15:12] : idx_q == 3'd1 ? word_q[11:8] :
               idx_q == 3'd2 ? word_q[7:4] : word_q[3:0];
  assign tx_data = idx_q < 3'd4 ? hex_ascii(nib) : idx_q == 3'd4 ? CR : LF;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    word_d = word_q;
    idx_d = idx_q;
    case (state_q)
      IDLE:    state_d = start ? RD_REQ : IDLE;
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: state_d = LATCH;
      LATCH: begin
        word_d = ram_data;
        idx_d = 3'd0;
        state_d = SEND;
      end
      SEND:    state_d = tx_busy ? SEND : WAIT_TX;
      WAIT_TX: begin
        if (tx_done) begin
          state_d = idx_q == 3'd5 ? NEXT : SEND;
          idx_d = idx_q == 3'd5 ? idx_q : idx_q + 3'd1;
        end
      end
      NEXT: begin
        state_d = addr_q == LAST_ADDR ? FINISH : RD_REQ;
        addr_d = addr_q == LAST_ADDR ? addr_q : addr_q + ADDR_W'(1);
      end
      FINISH: begin
        addr_d = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      word_q <= '0;
      idx_q <= 3'd0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      word_q <= word_d;
      idx_q <= idx_d;
    end
  end
  assign tx_start = state_q == SEND && !tx_busy;
  assign ram_rd_en = state_q == RD_REQ;
  assign ram_addr = addr_q;
  assign busy = state_q != IDLE;
  assign done = state_q == FINISH;
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk),
    .reset(reset),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx(uart_tx),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );
endmodule
